uart_bps_gen: RTL and testbench
===============================

Name: uart_bps_gen

Overview:
Parametrised UART baud-rate generator for both the TX and RX paths. It produces one-cycle mid-bit and end-of-bit strobes from a run-time programmable divisor. The divisor has an integer part and a fractional part, and the fractional part is resolved with a phase accumulator. It also tracks the bit index within a frame and supports continuous or single-shot framing. It sits between the UART shifters and the register/config interface, clocked by the 200 MHz system clock.

Parameters:
CLK_FREQ, 200000000, system clock frequency in Hz (elaboration only).
DEFAULT_BAUD, 115200, baud rate loaded at reset.
CNT_W, 16, width of the bit-period counter and of the integer divisor.
FRAC_W, 4, width of the fractional divisor and of the phase accumulator.
FRAME_BITS, 10, bit periods per frame (start + 8 data + stop); must be 2..255.
DEF_INT, CLK_FREQ/DEFAULT_BAUD, reset integer divisor (1736 at defaults).
DEF_FRAC, (CLK_FREQ*2^FRAC_W/DEFAULT_BAUD) mod 2^FRAC_W, reset fractional divisor (1 at defaults).

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-high.
en  in  1  level enable; high = run, low = return to IDLE.
single_shot  in  1  1 = stop after one frame; sampled only when leaving IDLE.
cfg_wr  in  1  one-cycle divisor write strobe.
cfg_div_int  in  CNT_W  integer divisor; values below 4 are clamped to 4.
cfg_div_frac  in  FRAC_W  fractional divisor, in units of 1/2^FRAC_W clk.
cfg_pending  out  1  a written divisor is waiting to be applied.
bps_clk_half  out  1  one-cycle mid-bit strobe.
bps_clk_total  out  1  one-cycle end-of-bit strobe.
bit_idx  out  8  index of the current bit within the frame (0..FRAME_BITS-1).
frame_done  out  1  one-cycle strobe on the final bit's end-of-bit strobe.
busy  out  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state = IDLE; counter = 0; phase accumulator acc = 0; bit_idx = 0.
  - All strobes = 0; busy = 0; cfg_pending = 0.
  - Active divisor = DEF_INT/DEF_FRAC; any pending divisor is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when en = 1; single_shot is latched on this transition.
  - RUN -> IDLE whenever en = 0. This is a synchronous clear of counter, acc and bit_idx. No strobes are issued in the cycle en is seen low.
  - RUN -> DONE on frame_done when latched single_shot = 1.
  - RUN stays in RUN on frame_done when single_shot = 0; bit_idx wraps to 0.
  - DONE -> IDLE when en = 0. While in DONE, the counter is held at 0 and no strobes are issued.
- Bit-period timing:
  - At each bit start (the IDLE->RUN cycle and every bps_clk_total cycle): {carry, acc} <= acc + div_frac, computed in FRAC_W+1 bits.
  - Period of that bit P = div_int + carry.
  - The counter runs 0..P-1 and increments every clk in RUN.
  - bps_clk_total = 1 when in RUN and counter == P-1; the counter returns to 0 on the next cycle.
  - bps_clk_half = 1 when in RUN and counter == (div_int>>1)-1. The half point ignores carry.
  - The first strobe after entering RUN is bps_clk_half, (div_int>>1) cycles after the entry cycle.
- bit_idx increments on bps_clk_total.
  - frame_done = bps_clk_total AND bit_idx == FRAME_BITS-1, asserted in the same cycle.
  - bit_idx then wraps to 0.
- Divisor update:
  - cfg_wr captures cfg_div_int (after clamping) and cfg_div_frac into a pending register; cfg_pending <= 1 on the next cycle.
  - In IDLE or DONE, the pending value is applied on the next cycle and cfg_pending clears.
  - In RUN, the pending value is applied only at a frame boundary, i.e. it becomes active for bit 0 of the next frame. acc is reset to 0 at that point.
  - cfg_wr in the same cycle as frame_done is bypassed and applied at that boundary directly.
  - Repeated cfg_wr before application: last write wins.
- Width: the counter is CNT_W bits. div_int = 2^CNT_W-1 with carry = 1 is clamped so that P does not exceed 2^CNT_W-1. No wrap of the counter is permitted.
- All outputs are driven from registered state; decode is combinational from registers only.

Test Plan:
1. Reset defaults: release rst, en=1 at 200 MHz, cfg unused -> half at counter 867; periods of 1736 clk except 1737 on every 16th bit (acc carry); frame_done after 10 bits.
2. Integer divisor: cfg_wr div_int=10, frac=0 while IDLE, then en=1 -> half 5 cycles after entry; total every 10 clk; frame_done every 100 clk with bit_idx 0..9 wrapping.
3. Fractional divisor: div_int=10, frac=8 -> bit periods alternate 10, 11 (first is 10); 16 bits take exactly 168 clk.
4. Mid-frame reconfiguration: RUN at div 10, cfg_wr div 20 at bit 3 -> cfg_pending=1; bit periods stay 10 until frame_done, then 20 from bit 0; cfg_pending clears that cycle. Also cfg_wr coincident with frame_done -> new value applied immediately.
5. Single-shot and en drop: single_shot=1 -> exactly 10 total strobes, then busy stays 1 with no strobes until en=0. Separately, en=0 at bit 4 -> next cycle counter=0, bit_idx=0, busy=0, no strobe.
6. Clamp and async reset: cfg div_int=2 -> period 4, half at counter 1. Assert rst mid-bit -> all outputs 0 immediately; the divisor reverts to 1736/1.

Source files
------------

// File: rtl/uart_bps_gen_if.sv
// ============================================================================
// uart_bps_gen_if : run control, divisor config and strobe bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface uart_bps_gen_if #(
    parameter int CNT_W  = 16,
    parameter int FRAC_W = 4
);
    logic              en;
    logic              single_shot;
    logic              cfg_wr;
    logic [CNT_W-1:0]  cfg_div_int;
    logic [FRAC_W-1:0] cfg_div_frac;
    logic              cfg_pending;
    logic              bps_clk_half;
    logic              bps_clk_total;
    logic [7:0]        bit_idx;
    logic              frame_done;
    logic              busy;

    modport master (
        output en, single_shot, cfg_wr, cfg_div_int, cfg_div_frac,
        input  cfg_pending, bps_clk_half, bps_clk_total, bit_idx, frame_done, busy
    );

    modport slave (
        input  en, single_shot, cfg_wr, cfg_div_int, cfg_div_frac,
        output cfg_pending, bps_clk_half, bps_clk_total, bit_idx, frame_done, busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_bps_gen.sv
// ============================================================================
// uart_bps_gen : UART baud strobe generator, fractional divisor, frame tracking
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_bps_gen #(
    parameter int CLK_FREQ     = 200000000,
    parameter int DEFAULT_BAUD = 115200,
    parameter int CNT_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int FRAME_BITS   = 10,
    parameter int DEF_INT      = CLK_FREQ / DEFAULT_BAUD,
    parameter int DEF_FRAC     = int'(((64'(CLK_FREQ) << FRAC_W) / 64'(DEFAULT_BAUD))
                                      % (64'd1 << FRAC_W))
) (
    input  logic             clk,
    input  logic             rst,
    uart_bps_gen_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  c_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_INT_MIN  = CNT_W'(4);
    localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  c_DEF_INT  = CNT_W'(DEF_INT);
    localparam logic [FRAC_W-1:0] c_DEF_FRAC = FRAC_W'(DEF_FRAC);
    localparam logic [7:0]        c_LAST_BIT = 8'(FRAME_BITS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_period;
    logic [FRAC_W-1:0] r_acc;
    logic [7:0]        r_bit_idx;
    logic              r_ss;
    logic [CNT_W-1:0]  r_div_int;
    logic [FRAC_W-1:0] r_div_frac;
    logic [CNT_W-1:0]  r_pend_int;
    logic [FRAC_W-1:0] r_pend_frac;
    logic              r_pending;

    logic              w_run;
    logic              w_total;
    logic              w_half;
    logic              w_frame_done;
    logic [CNT_W-1:0]  w_cfg_int;
    logic              w_bypass;
    logic              w_apply;
    logic [CNT_W-1:0]  w_new_int;
    logic [FRAC_W-1:0] w_new_frac;
    logic [FRAC_W-1:0] w_acc_base;
    logic [FRAC_W:0]   w_sum;
    logic [CNT_W:0]    w_per_raw;
    logic [CNT_W-1:0]  w_per;

    // Strobes are suppressed in the cycle en is seen low, before the clear lands.
    assign w_run        = (r_state == S_RUN) && bus.en;
    assign w_total      = w_run && (r_cnt == r_period - c_ONE);
    assign w_half       = w_run && (r_cnt == (r_div_int >> 1) - c_ONE);
    assign w_frame_done = w_total && (r_bit_idx == c_LAST_BIT);

    assign w_cfg_int  = (bus.cfg_div_int < c_INT_MIN) ? c_INT_MIN : bus.cfg_div_int;
    assign w_bypass   = w_frame_done && bus.cfg_wr;
    assign w_apply    = (r_state == S_RUN) ? (w_frame_done && (r_pending || bus.cfg_wr))
                                           : r_pending;
    assign w_new_int  = !w_apply ? r_div_int  : (w_bypass ? w_cfg_int        : r_pend_int);
    assign w_new_frac = !w_apply ? r_div_frac : (w_bypass ? bus.cfg_div_frac : r_pend_frac);

    // Bit-start arithmetic: phase accumulator carry stretches this bit by one clk.
    assign w_acc_base = w_apply ? '0 : r_acc;
    assign w_sum      = {1'b0, w_acc_base} + {1'b0, w_new_frac};
    assign w_per_raw  = {1'b0, w_new_int} + {{CNT_W{1'b0}}, w_sum[FRAC_W]};
    assign w_per      = w_per_raw[CNT_W] ? c_CNT_MAX : w_per_raw[CNT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.en) w_state_nxt = S_RUN;
            S_RUN: begin
                if (!bus.en)                  w_state_nxt = S_IDLE;
                else if (w_frame_done && r_ss) w_state_nxt = S_DONE;
            end
            S_DONE: if (!bus.en) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_period    <= c_DEF_INT;
            r_acc       <= '0;
            r_bit_idx   <= '0;
            r_ss        <= 1'b0;
            r_div_int   <= c_DEF_INT;
            r_div_frac  <= c_DEF_FRAC;
            r_pend_int  <= c_DEF_INT;
            r_pend_frac <= c_DEF_FRAC;
            r_pending   <= 1'b0;
        end else begin
            if (bus.cfg_wr && !w_bypass) begin
                r_pend_int  <= w_cfg_int;
                r_pend_frac <= bus.cfg_div_frac;
                r_pending   <= 1'b1;
            end else if (w_apply) begin
                r_pending   <= 1'b0;
            end
            if (w_apply) begin
                r_div_int  <= w_new_int;
                r_div_frac <= w_new_frac;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    if (bus.en) begin
                        r_acc    <= w_sum[FRAC_W-1:0];
                        r_period <= w_per;
                        r_ss     <= bus.single_shot;
                    end
                end
                S_RUN: begin
                    if (!bus.en) begin
                        r_cnt     <= '0;
                        r_acc     <= '0;
                        r_bit_idx <= '0;
                    end else if (w_total) begin
                        r_cnt     <= '0;
                        r_acc     <= w_sum[FRAC_W-1:0];
                        r_period  <= w_per;
                        r_bit_idx <= w_frame_done ? 8'd0 : r_bit_idx + 8'd1;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                S_DONE: begin
                    r_cnt <= '0;
                    if (!bus.en) begin
                        r_acc     <= '0;
                        r_bit_idx <= '0;
                    end
                end
                default: begin
                    r_cnt     <= '0;
                    r_acc     <= '0;
                    r_bit_idx <= '0;
                end
            endcase
        end
    end

    assign bus.cfg_pending   = r_pending;
    assign bus.bps_clk_half  = w_half;
    assign bus.bps_clk_total = w_total;
    assign bus.bit_idx       = r_bit_idx;
    assign bus.frame_done    = w_frame_done;
    assign bus.busy          = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_bps_gen.sv
// ============================================================================
// tb_uart_bps_gen : directed vector bench for uart_bps_gen
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_bps_gen;

    localparam int CNT_W  = 16;
    localparam int FRAC_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #2.5 clk = ~clk;

    uart_bps_gen_if #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) u_if ();

    uart_bps_gen #(
        .CLK_FREQ     (200000000),
        .DEFAULT_BAUD (115200),
        .CNT_W        (CNT_W),
        .FRAC_W       (FRAC_W),
        .FRAME_BITS   (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    typedef struct {
        logic [15:0] div_int;
        logic [3:0]  div_frac;
        int          half_dt;
        int          p0;
        int          p1;
        int          p2;
        int          p3;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Counts negedges until the chosen strobe is seen; dt is the count.
    task automatic wait_strobe(input bit want_total, input int limit, output int dt);
        dt = 0;
        while (1) begin
            @(negedge clk);
            dt++;
            if (want_total ? (u_if.bps_clk_total === 1'b1) : (u_if.bps_clk_half === 1'b1))
                return;
            if (dt >= limit) begin
                n_chk++;
                n_fail++;
                $display("FAIL timeout waiting for %s: got none in %0d cycles, expected a strobe",
                         want_total ? "total" : "half", limit);
                return;
            end
        end
    endtask

    task automatic wait_fd(output int el);
        int dt;
        el = 0;
        for (int i = 0; i < 12; i++) begin
            wait_strobe(1'b1, 200, dt);
            el += dt;
            if (u_if.frame_done === 1'b1) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL timeout waiting for frame_done: got none, expected one within 12 bits");
    endtask

    task automatic cfg_write(input logic [15:0] di, input logic [3:0] df);
        u_if.cfg_wr       = 1'b1;
        u_if.cfg_div_int  = di;
        u_if.cfg_div_frac = df;
        @(negedge clk);
        u_if.cfg_wr       = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   dt;
        int   dt2;
        int   el;
        int   n_tot;
        int   n_half;
        int   n_fd;

        vecs[0] = '{16'd10, 4'd0,  5, 10, 10, 10, 10};
        vecs[1] = '{16'd10, 4'd8,  5, 10, 11, 10, 11};
        vecs[2] = '{16'd2,  4'd0,  2,  4,  4,  4,  4};
        vecs[3] = '{16'd9,  4'd12, 4,  9, 10, 10, 10};
        vecs[4] = '{16'd3,  4'd15, 2,  4,  5,  5,  5};
        vecs[5] = '{16'd5,  4'd1,  2,  5,  5,  5,  5};

        u_if.en           = 1'b0;
        u_if.single_shot  = 1'b0;
        u_if.cfg_wr       = 1'b0;
        u_if.cfg_div_int  = '0;
        u_if.cfg_div_frac = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",        32'(u_if.busy),          0);
        check("rst_half",        32'(u_if.bps_clk_half),  0);
        check("rst_total",       32'(u_if.bps_clk_total), 0);
        check("rst_frame_done",  32'(u_if.frame_done),    0);
        check("rst_bit_idx",     32'(u_if.bit_idx),       0);
        check("rst_cfg_pending", 32'(u_if.cfg_pending),   0);
        rst = 1'b0;
        @(negedge clk);

        // Default divisor 1736 + 1/16: every 16th bit is 1737
        u_if.en = 1'b1;
        wait_strobe(1'b0, 2000, dt);
        check("t1_half_dt", 32'(dt), 868);
        for (int k = 0; k < 16; k++) begin
            wait_strobe(1'b1, 2000, dt);
            check($sformatf("t1_period[%0d]", k), 32'(dt),
                  (k == 0) ? 32'd868 : ((k == 15) ? 32'd1737 : 32'd1736));
            check($sformatf("t1_bit_idx[%0d]", k), 32'(u_if.bit_idx), 32'(k % 10));
            check($sformatf("t1_frame_done[%0d]", k), 32'(u_if.frame_done),
                  32'((k % 10) == 9));
        end
        u_if.en = 1'b0;
        @(negedge clk);
        check("t1_idle_busy", 32'(u_if.busy), 0);

        // Table of divisors programmed in IDLE
        for (int v = 0; v < 6; v++) begin
            cfg_write(vecs[v].div_int, vecs[v].div_frac);
            check($sformatf("vec%0d_pending_set", v), 32'(u_if.cfg_pending), 1);
            @(negedge clk);
            check($sformatf("vec%0d_pending_clr", v), 32'(u_if.cfg_pending), 0);
            u_if.en = 1'b1;
            wait_strobe(1'b0, 200, dt);
            check($sformatf("vec%0d_half", v), 32'(dt), 32'(vecs[v].half_dt));
            wait_strobe(1'b1, 200, dt2);
            check($sformatf("vec%0d_p0", v), 32'(dt + dt2), 32'(vecs[v].p0));
            wait_strobe(1'b1, 200, dt);
            check($sformatf("vec%0d_p1", v), 32'(dt), 32'(vecs[v].p1));
            wait_strobe(1'b1, 200, dt);
            check($sformatf("vec%0d_p2", v), 32'(dt), 32'(vecs[v].p2));
            wait_strobe(1'b1, 200, dt);
            check($sformatf("vec%0d_p3", v), 32'(dt), 32'(vecs[v].p3));
            check($sformatf("vec%0d_bit_idx", v), 32'(u_if.bit_idx), 3);
            u_if.en = 1'b0;
            @(negedge clk);
        end

        // 16 fractional bits at 10 + 8/16
        cfg_write(16'd10, 4'd8);
        @(negedge clk);
        u_if.en = 1'b1;
        el = 0;
        for (int k = 0; k < 16; k++) begin
            wait_strobe(1'b1, 200, dt);
            el += dt;
        end
        check("t3_16_bits", 32'(el), 168);
        u_if.en = 1'b0;
        @(negedge clk);

        // Mid-frame reconfiguration, then a write coincident with frame_done
        cfg_write(16'd10, 4'd0);
        @(negedge clk);
        u_if.en = 1'b1;
        wait_fd(el);
        check("t4_frame_len", 32'(el), 100);
        check("t4_fd_bit_idx", 32'(u_if.bit_idx), 9);
        for (int k = 0; k < 3; k++) wait_strobe(1'b1, 200, dt);
        @(negedge clk);
        check("t4_bit3", 32'(u_if.bit_idx), 3);
        cfg_write(16'd20, 4'd0);
        check("t4_pending", 32'(u_if.cfg_pending), 1);
        wait_strobe(1'b1, 200, dt);
        check("t4_bit3_period", 32'(dt + 2), 10);
        for (int k = 4; k < 10; k++) begin
            wait_strobe(1'b1, 200, dt);
            check($sformatf("t4_old_period[%0d]", k), 32'(dt), 10);
        end
        check("t4_boundary_fd", 32'(u_if.frame_done), 1);
        check("t4_boundary_pending", 32'(u_if.cfg_pending), 1);
        @(negedge clk);
        check("t4_pending_cleared", 32'(u_if.cfg_pending), 0);
        wait_strobe(1'b0, 200, dt);
        check("t4_new_half", 32'(dt + 1), 10);
        wait_strobe(1'b1, 200, dt);
        check("t4_new_period", 32'(dt), 10);
        check("t4_new_bit_idx", 32'(u_if.bit_idx), 0);
        wait_fd(el);
        check("t4_new_frame_rest", 32'(el), 180);
        cfg_write(16'd8, 4'd0);
        check("t4_bypass_not_pending", 32'(u_if.cfg_pending), 0);
        wait_strobe(1'b0, 200, dt);
        check("t4_bypass_half", 32'(dt + 1), 4);
        wait_strobe(1'b1, 200, dt);
        check("t4_bypass_period", 32'(dt), 4);
        u_if.en = 1'b0;
        @(negedge clk);

        // Single-shot frame
        cfg_write(16'd10, 4'd0);
        @(negedge clk);
        u_if.single_shot = 1'b1;
        u_if.en          = 1'b1;
        n_tot = 0; n_half = 0; n_fd = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (u_if.bps_clk_total === 1'b1) n_tot++;
            if (u_if.bps_clk_half === 1'b1)  n_half++;
            if (u_if.frame_done === 1'b1)    n_fd++;
        end
        check("t5_ss_totals", 32'(n_tot), 10);
        check("t5_ss_halves", 32'(n_half), 10);
        check("t5_ss_frame_done", 32'(n_fd), 1);
        check("t5_ss_busy", 32'(u_if.busy), 1);
        n_tot = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (u_if.bps_clk_total === 1'b1 || u_if.bps_clk_half === 1'b1) n_tot++;
        end
        check("t5_done_quiet", 32'(n_tot), 0);
        check("t5_done_busy", 32'(u_if.busy), 1);
        u_if.en          = 1'b0;
        u_if.single_shot = 1'b0;
        @(negedge clk);
        check("t5_done_to_idle", 32'(u_if.busy), 0);

        // en drop in the end-of-bit cycle of bit 4
        u_if.en = 1'b1;
        for (int k = 0; k < 4; k++) wait_strobe(1'b1, 200, dt);
        repeat (10) @(negedge clk);
        check("t5_pre_drop_total", 32'(u_if.bps_clk_total), 1);
        check("t5_pre_drop_idx", 32'(u_if.bit_idx), 4);
        u_if.en = 1'b0;
        #1;
        check("t5_drop_no_total", 32'(u_if.bps_clk_total), 0);
        check("t5_drop_no_fd", 32'(u_if.frame_done), 0);
        @(negedge clk);
        check("t5_drop_busy", 32'(u_if.busy), 0);
        check("t5_drop_bit_idx", 32'(u_if.bit_idx), 0);
        check("t5_drop_total", 32'(u_if.bps_clk_total), 0);
        u_if.en = 1'b1;
        wait_strobe(1'b0, 200, dt);
        check("t5_restart_half", 32'(dt), 5);
        u_if.en = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-bit with a pending divisor
        u_if.en = 1'b1;
        for (int k = 0; k < 2; k++) wait_strobe(1'b1, 200, dt);
        cfg_write(16'd20, 4'd0);
        check("t6_pending_before_rst", 32'(u_if.cfg_pending), 1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_busy", 32'(u_if.busy), 0);
        check("t6_rst_bit_idx", 32'(u_if.bit_idx), 0);
        check("t6_rst_pending", 32'(u_if.cfg_pending), 0);
        check("t6_rst_half", 32'(u_if.bps_clk_half), 0);
        check("t6_rst_total", 32'(u_if.bps_clk_total), 0);
        u_if.en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        u_if.en = 1'b1;
        wait_strobe(1'b0, 2000, dt);
        check("t6_default_half", 32'(dt), 868);
        wait_strobe(1'b1, 2000, dt);
        check("t6_default_period", 32'(dt), 868);
        u_if.en = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
